// File: rtl/sva_rep_multi_checker_if.sv
// Bundle of user-domain inputs and checker result outputs for sva_rep_multi_checker.
// Optional error-info signals exist only when SVA_ERR_INFO_EN is defined.
interface sva_rep_multi_checker_if #(
    parameter int unsigned THREADS     = 4,
`ifdef SVA_ERR_INFO_EN
    parameter int unsigned TIMER_WIDTH = 16,
`endif
    parameter int unsigned CNT_W       = 16
);
    localparam int unsigned ACW = $clog2(THREADS + 1);

    logic             gclk;
    logic             grst;
    logic             trig;
    logic             sig;
    logic             done;
    logic             busy;
    logic             succ;
    logic             fail;
    logic             overflow;
    logic             overrun;
    logic [ACW-1:0]   active_cnt;
    logic [CNT_W-1:0] succ_cnt;
    logic [CNT_W-1:0] fail_cnt;
`ifdef SVA_ERR_INFO_EN
    logic [TIMER_WIDTH-1:0] err_start;
    logic                   err_valid;

    modport master (output gclk, grst, trig, sig, done,
                    input  busy, succ, fail, overflow, overrun, active_cnt,
                           succ_cnt, fail_cnt, err_start, err_valid);
    modport slave  (input  gclk, grst, trig, sig, done,
                    output busy, succ, fail, overflow, overrun, active_cnt,
                           succ_cnt, fail_cnt, err_start, err_valid);
`else
    modport master (output gclk, grst, trig, sig, done,
                    input  busy, succ, fail, overflow, overrun, active_cnt,
                           succ_cnt, fail_cnt);
    modport slave  (input  gclk, grst, trig, sig, done,
                    output busy, succ, fail, overflow, overrun, active_cnt,
                           succ_cnt, fail_cnt);
`endif
endinterface

// File: rtl/sva_rep_multi_checker.sv
// Multi-attempt checker for  trig |=> sig[*REP_MIN:REP_MAX] ##1 done.
// User signals are sampled on sys_clk; each gclk rising edge (tick) triggers one scan
// over the thread table (one slot per cycle) followed by a spawn cycle.
// Optional feature macro: SVA_ERR_INFO_EN (adds err_start/err_valid).
module sva_rep_multi_checker #(
    parameter int unsigned THREADS     = 4,
    parameter int unsigned REP_MIN     = 1,
    parameter int unsigned REP_MAX     = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMER_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    sva_rep_multi_checker_if.slave bus
);
    localparam int unsigned ACW = $clog2(THREADS + 1);
    localparam int unsigned RW  = $clog2(REP_MAX + 1);
    localparam int unsigned IW  = (THREADS > 1) ? $clog2(THREADS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SPAWN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             sync_q1, sync_d0;
    logic                   gclk_d1;
    logic                   tick_c, grst_s;
    logic                   trig_s, sig_s, done_s;
    logic [IW-1:0]          idx_q;
    logic [THREADS-1:0]     act_q;
    logic [RW-1:0]          cnt_q   [THREADS];
    logic [TIMER_WIDTH-1:0] start_q [THREADS];
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [RW-1:0]          cur_cnt;
    logic                   scan_start_c, eval_c, spawn_c, drop_c;
    logic                   hit_succ_c, hit_inc_c, hit_fail_c, alloc_c, ovf_c;
    logic                   free_found_c;
    logic [IW-1:0]          free_idx_c;
    logic [ACW-1:0]         live_c;
    logic                   busy_q, succ_q, fail_q, overflow_q, overrun_q;
    logic [ACW-1:0]         active_cnt_q;
    logic [CNT_W-1:0]       succ_cnt_q, fail_cnt_q;

    assign tick_c = sync_d0[4] & ~gclk_d1;
    assign grst_s = sync_d0[3];
    assign cur_cnt = cnt_q[idx_q];

    // Two-flop stage for {gclk, grst, trig, sig, done} plus gclk edge history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= '0;
            sync_d0 <= '0;
            gclk_d1 <= 1'b0;
        end else begin
            sync_q1 <= {bus.gclk, bus.grst, bus.trig, bus.sig, bus.done};
            sync_d0 <= sync_q1;
            gclk_d1 <= sync_d0[4];
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // FSM next state; synchronised grst forces IDLE from anywhere
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick_c) state_d = SCAN;
            SCAN:    if (idx_q == IW'(THREADS - 1)) state_d = SPAWN;
            SPAWN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (grst_s) state_d = IDLE;
    end

    // FSM outputs: scan/spawn strobes and per-slot verdict (done beats sig beats fail)
    always_comb begin
        scan_start_c = 1'b0;
        eval_c       = 1'b0;
        spawn_c      = 1'b0;
        drop_c       = 1'b0;
        if (!grst_s) begin
            scan_start_c = (state_q == IDLE) && tick_c;
            eval_c       = (state_q == SCAN);
            spawn_c      = (state_q == SPAWN);
            drop_c       = (state_q != IDLE) && tick_c;
        end
        hit_succ_c = eval_c && act_q[idx_q] && done_s && (cur_cnt >= RW'(REP_MIN));
        hit_inc_c  = eval_c && act_q[idx_q] && !hit_succ_c && sig_s && (cur_cnt < RW'(REP_MAX));
        hit_fail_c = eval_c && act_q[idx_q] && !hit_succ_c && !hit_inc_c;
        alloc_c    = spawn_c && trig_s && free_found_c;
        ovf_c      = spawn_c && trig_s && !free_found_c;
    end

    // Lowest-index free slot
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = int'(THREADS) - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IW'(i);
            end
        end
    end

    // Number of live slots
    always_comb begin
        live_c = '0;
        for (int i = 0; i < int'(THREADS); i++) live_c = live_c + ACW'(act_q[i]);
    end

    // Scan index, input snapshot and tick timer
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q   <= '0;
            trig_s  <= 1'b0;
            sig_s   <= 1'b0;
            done_s  <= 1'b0;
            timer_q <= '0;
        end else if (grst_s) begin
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            if (scan_start_c) begin
                idx_q  <= '0;
                trig_s <= sync_d0[2];
                sig_s  <= sync_d0[1];
                done_s <= sync_d0[0];
            end else if (eval_c) begin
                idx_q <= idx_q + IW'(1);
            end
            if (spawn_c) timer_q <= timer_q + TIMER_WIDTH'(1);
        end
    end

    // Thread table: free on verdict, advance repetition count, allocate on spawn
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            act_q <= '0;
            for (int i = 0; i < int'(THREADS); i++) begin
                cnt_q[i]   <= '0;
                start_q[i] <= '0;
            end
        end else if (grst_s) begin
            act_q <= '0;
        end else begin
            if (hit_succ_c || hit_fail_c) act_q[idx_q] <= 1'b0;
            if (hit_inc_c) cnt_q[idx_q] <= cur_cnt + RW'(1);
            if (alloc_c) begin
                act_q[free_idx_c]   <= 1'b1;
                cnt_q[free_idx_c]   <= '0;
                start_q[free_idx_c] <= timer_q;
            end
        end
    end

    // Registered result outputs, sticky overrun and saturating counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_q       <= 1'b0;
            succ_q       <= 1'b0;
            fail_q       <= 1'b0;
            overflow_q   <= 1'b0;
            overrun_q    <= 1'b0;
            active_cnt_q <= '0;
            succ_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            busy_q       <= (state_d != IDLE);
            succ_q       <= hit_succ_c;
            fail_q       <= hit_fail_c;
            overflow_q   <= ovf_c;
            active_cnt_q <= live_c;
            if (grst_s) begin
                overrun_q  <= 1'b0;
                succ_cnt_q <= '0;
                fail_cnt_q <= '0;
            end else begin
                if (drop_c) overrun_q <= 1'b1;
                if (hit_succ_c && (succ_cnt_q != {CNT_W{1'b1}})) succ_cnt_q <= succ_cnt_q + CNT_W'(1);
                if (hit_fail_c && (fail_cnt_q != {CNT_W{1'b1}})) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.succ       = succ_q;
    assign bus.fail       = fail_q;
    assign bus.overflow   = overflow_q;
    assign bus.overrun    = overrun_q;
    assign bus.active_cnt = active_cnt_q;
    assign bus.succ_cnt   = succ_cnt_q;
    assign bus.fail_cnt   = fail_cnt_q;

`ifdef SVA_ERR_INFO_EN
    logic [TIMER_WIDTH-1:0] err_start_q;
    logic                   err_valid_q;

    // Start tick of the first failing attempt since reset/grst
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_start_q <= '0;
            err_valid_q <= 1'b0;
        end else if (grst_s) begin
            err_start_q <= '0;
            err_valid_q <= 1'b0;
        end else if (hit_fail_c && !err_valid_q) begin
            err_start_q <= start_q[idx_q];
            err_valid_q <= 1'b1;
        end
    end

    assign bus.err_start = err_start_q;
    assign bus.err_valid = err_valid_q;
`endif
endmodule

// File: tb/tb_sva_rep_multi_checker.sv
// Bench for sva_rep_multi_checker: two instances (defaults, and REP_MAX=8 with 2-bit
// counters) share one stimulus stream and are compared against a per-tick table model.
module tb_sva_rep_multi_checker;
    localparam int unsigned THREADS = 4;
    localparam int unsigned REP_MIN = 1;
    localparam int QUIET = int'(THREADS) + 6;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic g_gclk = 1'b0, g_grst = 1'b0, g_trig = 1'b0, g_sig = 1'b0, g_done = 1'b0;

    always #5 sys_clk = ~sys_clk;

`ifdef SVA_ERR_INFO_EN
    sva_rep_multi_checker_if #(.THREADS(THREADS), .TIMER_WIDTH(16), .CNT_W(16)) ifa ();
    sva_rep_multi_checker_if #(.THREADS(THREADS), .TIMER_WIDTH(16), .CNT_W(2))  ifb ();
`else
    sva_rep_multi_checker_if #(.THREADS(THREADS), .CNT_W(16)) ifa ();
    sva_rep_multi_checker_if #(.THREADS(THREADS), .CNT_W(2))  ifb ();
`endif

    assign ifa.gclk = g_gclk;  assign ifb.gclk = g_gclk;
    assign ifa.grst = g_grst;  assign ifb.grst = g_grst;
    assign ifa.trig = g_trig;  assign ifb.trig = g_trig;
    assign ifa.sig  = g_sig;   assign ifb.sig  = g_sig;
    assign ifa.done = g_done;  assign ifb.done = g_done;

    sva_rep_multi_checker #(.THREADS(THREADS), .REP_MIN(REP_MIN), .REP_MAX(3), .CNT_W(16),
                            .TIMER_WIDTH(16)) dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ifa));
    sva_rep_multi_checker #(.THREADS(THREADS), .REP_MIN(REP_MIN), .REP_MAX(8), .CNT_W(2),
                            .TIMER_WIDTH(16)) dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(ifb));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_evt = 0;
    int last_acc = -1000;

    // Model: slot table per instance, advanced once per accepted tick
    int rep_max [2] = '{3, 8};
    int cmax    [2] = '{65535, 3};
    int m_act   [2][THREADS];
    int m_cnt   [2][THREADS];
    int m_start [2][THREADS];
    int m_timer [2];
    int m_succ  [2], m_fail [2];
    int m_succ_p[2], m_fail_p [2], m_ovf_p [2];
    int m_errv  [2], m_errs [2];
    int m_overrun;
    int p_succ  [2], p_fail [2], p_ovf [2];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_live(input int k);
        int n = 0;
        for (int i = 0; i < int'(THREADS); i++) n += m_act[k][i];
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(THREADS); i++) begin
                m_act[k][i] = 0; m_cnt[k][i] = 0; m_start[k][i] = 0;
            end
            m_timer[k] = 0; m_succ[k] = 0; m_fail[k] = 0; m_errv[k] = 0; m_errs[k] = 0;
        end
        m_overrun = 0;
    endtask

    task automatic model_apply(input int k, input int t, input int s, input int d);
        int fr = -1;
        for (int i = 0; i < int'(THREADS); i++) begin
            if (m_act[k][i] != 0) begin
                if (d != 0 && m_cnt[k][i] >= int'(REP_MIN)) begin
                    m_act[k][i] = 0; m_succ_p[k]++;
                    if (m_succ[k] < cmax[k]) m_succ[k]++;
                end else if (s != 0 && m_cnt[k][i] < rep_max[k]) begin
                    m_cnt[k][i]++;
                end else begin
                    m_act[k][i] = 0; m_fail_p[k]++;
                    if (m_fail[k] < cmax[k]) m_fail[k]++;
                    if (m_errv[k] == 0) begin m_errv[k] = 1; m_errs[k] = m_start[k][i]; end
                end
            end
        end
        for (int i = 0; i < int'(THREADS); i++) if (m_act[k][i] == 0 && fr < 0) fr = i;
        if (t != 0) begin
            if (fr >= 0) begin
                m_act[k][fr] = 1; m_cnt[k][fr] = 0; m_start[k][fr] = m_timer[k];
            end else m_ovf_p[k]++;
        end
        m_timer[k] = (m_timer[k] + 1) % 65536;
    endtask

    // A gclk rise closer than one full scan to the previous accepted one is dropped
    task automatic model_rise(input int t, input int s, input int d);
        last_evt = cyc;
        if (cyc - last_acc < int'(THREADS) + 2) m_overrun = 1;
        else begin
            last_acc = cyc;
            model_apply(0, t, s, d);
            model_apply(1, t, s, d);
        end
    endtask

    task automatic tick(input logic t, input logic s, input logic d, input int half);
        @(negedge sys_clk);
        g_trig = t; g_sig = s; g_done = d; g_gclk = 1'b1;
        model_rise(int'(t), int'(s), int'(d));
        repeat (half) @(negedge sys_clk);
        g_gclk = 1'b0;
        repeat (half) @(negedge sys_clk);
    endtask

    task automatic T(input logic t, input logic s, input logic d);
        tick(t, s, d, 8);
    endtask

    task automatic grst_pulse();
        @(negedge sys_clk);
        g_grst = 1'b1; model_clear(); last_evt = cyc;
        repeat (4) @(negedge sys_clk);
        g_grst = 1'b0; last_evt = cyc;
        repeat (14) @(negedge sys_clk);
    endtask

    // Tick followed by grst landing while the scan is still walking the table
    task automatic grst_mid_scan();
        @(negedge sys_clk);
        g_trig = 1'b0; g_sig = 1'b1; g_done = 1'b0; g_gclk = 1'b1;
        model_rise(0, 1, 0);
        repeat (2) @(negedge sys_clk);
        g_grst = 1'b1; model_clear(); last_evt = cyc;
        repeat (4) @(negedge sys_clk);
        g_grst = 1'b0; last_evt = cyc;
        repeat (2) @(negedge sys_clk);
        g_gclk = 1'b0;
        repeat (14) @(negedge sys_clk);
    endtask

    task automatic cmp_dut(input int k, input string nm, input logic busy, input logic [31:0] act,
                           input logic [31:0] sc, input logic [31:0] fc, input logic ovr);
        chk({nm, ".busy"}, 32'(busy), 32'd0);
        chk({nm, ".active_cnt"}, act, 32'(m_live(k)));
        chk({nm, ".succ_cnt"}, sc, 32'(m_succ[k]));
        chk({nm, ".fail_cnt"}, fc, 32'(m_fail[k]));
        chk({nm, ".overrun"}, 32'(ovr), 32'(m_overrun));
        chk({nm, ".succ_pulses"}, 32'(p_succ[k]), 32'(m_succ_p[k]));
        chk({nm, ".fail_pulses"}, 32'(p_fail[k]), 32'(m_fail_p[k]));
        chk({nm, ".ovf_pulses"}, 32'(p_ovf[k]), 32'(m_ovf_p[k]));
    endtask

    // Pulse accounting every cycle, model comparison on every settled cycle
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            p_succ[0] += int'(ifa.succ); p_fail[0] += int'(ifa.fail); p_ovf[0] += int'(ifa.overflow);
            p_succ[1] += int'(ifb.succ); p_fail[1] += int'(ifb.fail); p_ovf[1] += int'(ifb.overflow);
            if (cyc - last_evt >= QUIET) begin
                cmp_dut(0, "a", ifa.busy, 32'(ifa.active_cnt), 32'(ifa.succ_cnt), 32'(ifa.fail_cnt), ifa.overrun);
                cmp_dut(1, "b", ifb.busy, 32'(ifb.active_cnt), 32'(ifb.succ_cnt), 32'(ifb.fail_cnt), ifb.overrun);
`ifdef SVA_ERR_INFO_EN
                chk("a.err_valid", 32'(ifa.err_valid), 32'(m_errv[0]));
                chk("a.err_start", 32'(ifa.err_start), 32'(m_errs[0]));
                chk("b.err_valid", 32'(ifb.err_valid), 32'(m_errv[1]));
                chk("b.err_start", 32'(ifb.err_start), 32'(m_errs[1]));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            m_succ_p[k] = 0; m_fail_p[k] = 0; m_ovf_p[k] = 0;
            p_succ[k] = 0; p_fail[k] = 0; p_ovf[k] = 0;
        end
        repeat (3) @(negedge sys_clk);
        chk("rst.busy", 32'(ifa.busy), 32'd0);
        chk("rst.active_cnt", 32'(ifa.active_cnt), 32'd0);
        chk("rst.succ_cnt", 32'(ifa.succ_cnt), 32'd0);
        chk("rst.fail_cnt", 32'(ifb.fail_cnt), 32'd0);
        chk("rst.overrun", 32'(ifa.overrun), 32'd0);
        sys_rst_n = 1'b1;
        last_evt = cyc;
        repeat (12) @(negedge sys_clk);

        // trig, sig, sig, done -> one success
        T(1, 0, 0); T(0, 1, 0); T(0, 1, 0); T(0, 0, 1);
        chk("t1.a.succ_cnt", 32'(ifa.succ_cnt), 32'd1);
        chk("t1.a.fail_cnt", 32'(ifa.fail_cnt), 32'd0);
        chk("t1.b.succ_cnt", 32'(ifb.succ_cnt), 32'd1);
        chk("t1.a.active_cnt", 32'(ifa.active_cnt), 32'd0);
        grst_pulse();

        // sig held past REP_MAX without done -> fail on the 4th sig tick
        T(1, 0, 0); T(0, 1, 0); T(0, 1, 0); T(0, 1, 0);
        chk("t2.a.fail_before", 32'(ifa.fail_cnt), 32'd0);
        chk("t2.a.active_before", 32'(ifa.active_cnt), 32'd1);
        T(0, 1, 0);
        chk("t2.a.fail_cnt", 32'(ifa.fail_cnt), 32'd1);
        chk("t2.a.active_cnt", 32'(ifa.active_cnt), 32'd0);
        chk("t2.b.fail_cnt", 32'(ifb.fail_cnt), 32'd0);
`ifdef SVA_ERR_INFO_EN
        chk("t2.a.err_valid", 32'(ifa.err_valid), 32'd1);
        chk("t2.a.err_start", 32'(ifa.err_start), 32'd0);
`endif
        T(0, 0, 0);
        grst_pulse();

        // done with zero repetitions -> fail
        T(1, 0, 0); T(0, 0, 1);
        chk("t3.a.fail_cnt", 32'(ifa.fail_cnt), 32'd1);
        chk("t3.a.succ_cnt", 32'(ifa.succ_cnt), 32'd0);
        grst_pulse();

        // table fills up on the REP_MAX=8 instance -> overflow, no fail
        o0 = p_ovf[1];
        T(1, 1, 0); T(1, 1, 0); T(1, 1, 0); T(1, 1, 0); T(1, 1, 0);
        chk("t4.b.active_cnt", 32'(ifb.active_cnt), 32'd4);
        chk("t4.b.overflow", 32'(p_ovf[1] - o0), 32'd1);
        chk("t4.b.fail_cnt", 32'(ifb.fail_cnt), 32'd0);
        grst_pulse();

        // one success per tick in steady state; 2-bit counter saturates at 3
        for (int i = 0; i < 7; i++) T(1, 1, 1);
        chk("sat.a.succ_cnt", 32'(ifa.succ_cnt), 32'd5);
        chk("sat.b.succ_cnt", 32'(ifb.succ_cnt), 32'd3);
        chk("sat.a.active_cnt", 32'(ifa.active_cnt), 32'd2);
        grst_pulse();

        // three live slots, then grst lands mid-scan
        T(1, 0, 0); T(1, 0, 0); T(1, 1, 0); T(1, 1, 0);
        chk("t6.a.fail_cnt", 32'(ifa.fail_cnt), 32'd1);
        chk("t6.a.active_cnt", 32'(ifa.active_cnt), 32'd3);
        o0 = p_succ[0] + p_fail[0];
        grst_mid_scan();
        chk("t6.a.active_after", 32'(ifa.active_cnt), 32'd0);
        chk("t6.a.fail_after", 32'(ifa.fail_cnt), 32'd0);
        chk("t6.a.succ_after", 32'(ifa.succ_cnt), 32'd0);
        chk("t6.a.pulses", 32'(p_succ[0] + p_fail[0] - o0), 32'd0);

        // gclk period of 4 sys_clk -> overrun sticks until grst
        tick(0, 0, 0, 2); tick(0, 0, 0, 2); tick(0, 0, 0, 2);
        repeat (16) @(negedge sys_clk);
        chk("t5.a.overrun", 32'(ifa.overrun), 32'd1);
        chk("t5.b.overrun", 32'(ifb.overrun), 32'd1);
        repeat (8) @(negedge sys_clk);
        chk("t5.a.overrun_sticky", 32'(ifa.overrun), 32'd1);
        grst_pulse();
        chk("t5.a.overrun_clr", 32'(ifa.overrun), 32'd0);

        T(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
